// File: rtl/ibex_defines.sv
// Shared definitions for the CHERI load/store unit: FSM state
// encoding, capability width and beat count.
package ibex_defines;

   localparam int CAP_WIDTH = 93;
   localparam int CAP_BEATS = 3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      FAULT
   } cheri_lsu_state_e;

endpackage

// File: rtl/ibex_cheri_lsu.sv
// CHERI load/store unit: word or 3-beat capability accesses on a 32-bit bus.
// Optional macro CHERI_CAP_ALIGN_CHECK_EN enforces 16-byte capability alignment.
module ibex_cheri_lsu
   import ibex_defines::*;
#(
   parameter int CapWidth = CAP_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic                cap_i,
   input  logic [31:0]         addr_i,
   input  logic [CapWidth-1:0] wdata_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [CapWidth-1:0] rdata_o,
   output logic                err_o,
   output logic                misaligned_o,
   output logic                data_req_o,
   input  logic                data_gnt_i,
   input  logic                data_rvalid_i,
   input  logic                data_err_i,
   output logic [31:0]         data_addr_o,
   output logic                data_we_o,
   output logic [3:0]          data_be_o,
   output logic [31:0]         data_wdata_o,
   input  logic [31:0]         data_rdata_i
);

   cheri_lsu_state_e state_q, state_d;

   logic [1:0]          beat_q, beat_d;
   logic                we_q;
   logic                cap_q;
   logic [29:0]         addr_q;
   logic [CapWidth-1:0] wdata_q;
   logic [CapWidth-1:0] acc_q, acc_d;

   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                mis_q, mis_d;
   logic [CapWidth-1:0] rdata_q, rdata_d;

   logic                word_ok;
   logic                cap_ok;
   logic                aligned;
   logic                last_beat;
   logic                in_req;
   logic [31:0]         beat_wdata;

   assign word_ok = (addr_i[1:0] == 2'b00);
`ifdef CHERI_CAP_ALIGN_CHECK_EN
   assign cap_ok  = (addr_i[3:0] == 4'h0);
`else
   assign cap_ok  = (addr_i[1:0] == 2'b00);
`endif
   assign aligned = cap_i ? cap_ok : word_ok;

   assign last_beat = cap_q ? (beat_q == 2'(CAP_BEATS - 1))
                            : (beat_q == 2'd0);

   // Select the current 32-bit store beat; bits above CapWidth read as 0.
   always_comb begin
      beat_wdata = '0;
      for (int i = 0; i < CapWidth; i++) begin
         if (2'(i / 32) == beat_q) beat_wdata[i % 32] = wdata_q[i];
      end
   end

   assign in_req       = (state_q == REQ);
   assign busy_o       = (state_q != IDLE);
   assign data_req_o   = in_req;
   assign data_we_o    = in_req & we_q;
   assign data_be_o    = {4{in_req}};
   assign data_addr_o  = in_req ? ({addr_q, 2'b00} + {28'd0, beat_q, 2'b00})
                                : 32'd0;
   assign data_wdata_o = in_req ? beat_wdata : 32'd0;

   assign done_o       = done_q;
   assign err_o        = err_q;
   assign misaligned_o = mis_q;
   assign rdata_o      = rdata_q;

   // Next-state, beat sequencing, load accumulation and completion status.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               beat_d  = 2'd0;
               acc_d   = '0;
               state_d = aligned ? REQ : FAULT;
            end
         end
         REQ: begin
            if (data_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (data_rvalid_i) begin
               if (!we_q) begin
                  for (int i = 0; i < CapWidth; i++) begin
                     if (2'(i / 32) == beat_q) acc_d[i] = data_rdata_i[i % 32];
                  end
               end
               if (data_err_i || last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  err_d   = data_err_i;
                  rdata_d = we_q ? '0 : acc_d;
               end else begin
                  beat_d  = beat_q + 2'd1;
                  state_d = REQ;
               end
            end
         end
         FAULT: begin
            state_d = IDLE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, beat counter, accumulator and registered results.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= 2'd0;
         acc_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
      end
   end

   // Capture the request attributes when a new access is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         cap_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && req_i) begin
         we_q   <= we_i;
         cap_q  <= cap_i;
         addr_q <= addr_i[31:2];
         if (we_i) wdata_q <= wdata_i;
      end
   end

endmodule

// File: tb/tb_ibex_cheri_lsu.sv
// Directed bench for ibex_cheri_lsu with a negedge-driven bus responder.
// Honours CHERI_CAP_ALIGN_CHECK_EN for the capability alignment case.
`timescale 1ns/1ps
module tb_ibex_cheri_lsu;

   localparam int CW = 93;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_i, we_i, cap_i;
   logic [31:0]   addr_i;
   logic [CW-1:0] wdata_i;
   logic          busy_o, done_o, err_o, misaligned_o;
   logic [CW-1:0] rdata_o;
   logic          data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
   logic [31:0]   data_addr_o, data_wdata_o, data_rdata_i;
   logic          data_we_o;
   logic [3:0]    data_be_o;

   int checks = 0;
   int fails  = 0;

   // bus responder configuration (written by tests)
   int          tr_id = 0;
   int          stall_beat = -1, stall_n = 0, err_beat = -1;
   int          rvd_beat = -1, rvd_n = 0;
   logic [31:0] rbeat [4];

   // responder state (written only by responder)
   int          seen_id = 0;
   int          g = 0, pend = 0, pend_beat = 0, pend_wait = 0;
   int          stalled = 0, req_seen = 0, rv_cnt = 0;
   logic [31:0] stall_addr = 0;
   logic [31:0] log_addr [4];
   logic [31:0] log_wdata [4];
   logic        log_we [4];
   logic [3:0]  log_be [4];

   always #5 clk = ~clk;

   ibex_cheri_lsu dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .cap_i(cap_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
      .err_o(err_o), .misaligned_o(misaligned_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
      .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
      .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rdata_i(data_rdata_i)
   );

   // Bus slave: grants on request (with optional stall), answers later.
   always @(negedge clk) begin
      if (tr_id != seen_id) begin
         seen_id = tr_id; g = 0; stalled = 0; req_seen = 0;
         stall_addr = 0; rv_cnt = 0;
      end
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
      if (pend != 0) begin
         if (pend_wait > 0) pend_wait--;
         else begin
            data_rvalid_i = 1;
            data_rdata_i  = rbeat[pend_beat];
            data_err_i    = (pend_beat == err_beat);
            pend = 0;
            rv_cnt++;
         end
      end else if (data_req_o) begin
         req_seen++;
         if (g == stall_beat && stalled < stall_n) begin
            stalled++;
            stall_addr = data_addr_o;
         end else begin
            data_gnt_i = 1;
            if (g < 4) begin
               log_addr[g] = data_addr_o; log_wdata[g] = data_wdata_o;
               log_we[g] = data_we_o; log_be[g] = data_be_o;
            end
            pend = 1; pend_beat = (g < 4) ? g : 3;
            pend_wait = (g == rvd_beat) ? rvd_n : 0;
            g++;
         end
      end
   end

   task automatic set_bus(input int sb, input int sn, input int eb,
                          input int rb, input int rn,
                          input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] b2);
      stall_beat = sb; stall_n = sn; err_beat = eb;
      rvd_beat = rb; rvd_n = rn;
      rbeat[0] = b0; rbeat[1] = b1; rbeat[2] = b2; rbeat[3] = 0;
   endtask

   // Issue one request at a negedge; return the cycle done_o is seen (-1 = none).
   task automatic do_access(input logic w, input logic c, input logic [31:0] a,
                            input logic [CW-1:0] wd, output int cyc);
      tr_id++;
      req_i = 1; we_i = w; cap_i = c; addr_i = a; wdata_i = wd;
      @(posedge clk); @(negedge clk);
      req_i = 0; we_i = 0; cap_i = 0; addr_i = 0; wdata_i = 0;
      cyc = -1;
      for (int n = 1; n < 40; n++) begin
         if (done_o === 1'b1) begin cyc = n; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_i = 1; req_i = 0; we_i = 0; cap_i = 0; addr_i = 0; wdata_i = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, done_o, err_o, misaligned_o, data_req_o, data_we_o} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b exp 000000",
            {busy_o, done_o, err_o, misaligned_o, data_req_o, data_we_o});
      end
      checks++;
      if (rdata_o !== '0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", rdata_o); end
      checks++;
      if ({data_addr_o, data_wdata_o, data_be_o} !== 68'h0) begin
         fails++; $display("FAIL reset_bus: got %h %h %h exp 0", data_addr_o, data_wdata_o, data_be_o);
      end
      rst_i = 0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_idle: busy got %b exp 0", busy_o); end
   endtask

   task automatic test_word_load();
      int cyc;
      set_bus(-1, 0, -1, -1, 0, 32'hDEADBEEF, 0, 0);
      do_access(0, 0, 32'h1000, '0, cyc);
      checks++;
      if (cyc !== 3) begin fails++; $display("FAIL wload_cyc: got %0d exp 3", cyc); end
      checks++;
      if (log_addr[0] !== 32'h1000 || log_we[0] !== 1'b0) begin
         fails++; $display("FAIL wload_bus: addr %h we %b exp 1000 0", log_addr[0], log_we[0]);
      end
      checks++;
      if (rdata_o !== CW'(32'hDEADBEEF)) begin fails++; $display("FAIL wload_data: got %h exp DEADBEEF", rdata_o); end
      checks++;
      if ({err_o, misaligned_o} !== 2'b00 || g !== 1) begin
         fails++; $display("FAIL wload_stat: err %b mis %b beats %0d exp 0 0 1", err_o, misaligned_o, g);
      end
   endtask

   task automatic test_word_store();
      int cyc;
      set_bus(-1, 0, -1, -1, 0, 32'h77777777, 0, 0);
      do_access(1, 0, 32'h1004, {29'h0AAAAAAA, 32'h55555555, 32'hCAFEF00D}, cyc);
      checks++;
      if (cyc !== 3) begin fails++; $display("FAIL wstore_cyc: got %0d exp 3", cyc); end
      checks++;
      if (log_wdata[0] !== 32'hCAFEF00D || log_we[0] !== 1'b1 || log_addr[0] !== 32'h1004) begin
         fails++; $display("FAIL wstore_bus: wd %h we %b addr %h exp CAFEF00D 1 1004",
            log_wdata[0], log_we[0], log_addr[0]);
      end
      checks++;
      if (rdata_o !== '0 || g !== 1) begin fails++; $display("FAIL wstore_rdata: got %h beats %0d exp 0 1", rdata_o, g); end
   endtask

   task automatic test_cap_store();
      int cyc;
      set_bus(-1, 0, -1, -1, 0, 0, 0, 0);
      do_access(1, 1, 32'h2000, {29'h1ABCDEF0, 32'h22222222, 32'h11111111}, cyc);
      checks++;
      if (cyc !== 7) begin fails++; $display("FAIL cstore_cyc: got %0d exp 7", cyc); end
      checks++;
      if (log_addr[0] !== 32'h2000 || log_addr[1] !== 32'h2004 || log_addr[2] !== 32'h2008) begin
         fails++; $display("FAIL cstore_addr: got %h %h %h exp 2000 2004 2008",
            log_addr[0], log_addr[1], log_addr[2]);
      end
      checks++;
      if (log_wdata[0] !== 32'h11111111 || log_wdata[1] !== 32'h22222222 || log_wdata[2] !== 32'h1ABCDEF0) begin
         fails++; $display("FAIL cstore_wdata: got %h %h %h exp 11111111 22222222 1ABCDEF0",
            log_wdata[0], log_wdata[1], log_wdata[2]);
      end
      checks++;
      if (log_be[1] !== 4'hF || rdata_o !== '0 || g !== 3) begin
         fails++; $display("FAIL cstore_misc: be %h rdata %h beats %0d exp F 0 3", log_be[1], rdata_o, g);
      end
   endtask

   task automatic test_cap_load_stall();
      int cyc;
      logic [CW-1:0] exp;
      exp = {29'h1FFFFFFF, 32'h89ABCDEF, 32'h01234567};
      set_bus(1, 2, -1, -1, 0, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF);
      do_access(0, 1, 32'h3000, '0, cyc);
      checks++;
      if (cyc !== 9) begin fails++; $display("FAIL cload_cyc: got %0d exp 9", cyc); end
      checks++;
      if (stalled !== 2 || stall_addr !== 32'h3004 || log_addr[1] !== 32'h3004) begin
         fails++; $display("FAIL cload_stall: stalls %0d addr %h gaddr %h exp 2 3004 3004",
            stalled, stall_addr, log_addr[1]);
      end
      checks++;
      if (rdata_o !== exp) begin fails++; $display("FAIL cload_data: got %h exp %h", rdata_o, exp); end
      checks++;
      if (log_addr[2] !== 32'h3008 || err_o !== 1'b0) begin
         fails++; $display("FAIL cload_b2: addr %h err %b exp 3008 0", log_addr[2], err_o);
      end
   endtask

   task automatic test_cap_load_err();
      int cyc;
      set_bus(-1, 0, 1, -1, 0, 32'hAAAA5555, 32'h12345678, 32'h9);
      do_access(0, 1, 32'h3100, '0, cyc);
      checks++;
      if (cyc !== 5) begin fails++; $display("FAIL cerr_cyc: got %0d exp 5", cyc); end
      checks++;
      if (err_o !== 1'b1 || misaligned_o !== 1'b0) begin
         fails++; $display("FAIL cerr_stat: err %b mis %b exp 1 0", err_o, misaligned_o);
      end
      checks++;
      if (rdata_o[31:0] !== 32'hAAAA5555) begin fails++; $display("FAIL cerr_data: got %h exp AAAA5555", rdata_o[31:0]); end
      @(negedge clk); @(negedge clk);
      checks++;
      if (g !== 2 || busy_o !== 1'b0) begin fails++; $display("FAIL cerr_abort: beats %0d busy %b exp 2 0", g, busy_o); end
   endtask

   task automatic test_misaligned();
      int cyc;
      logic [CW-1:0] exp;
      set_bus(-1, 0, -1, -1, 0, 32'hA, 32'hB, 32'hC);
      do_access(0, 0, 32'h1002, '0, cyc);
      checks++;
      if (cyc !== 2) begin fails++; $display("FAIL mis_word_cyc: got %0d exp 2", cyc); end
      checks++;
      if (misaligned_o !== 1'b1 || err_o !== 1'b0 || req_seen !== 0) begin
         fails++; $display("FAIL mis_word: mis %b err %b reqs %0d exp 1 0 0", misaligned_o, err_o, req_seen);
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || misaligned_o !== 1'b0) begin
         fails++; $display("FAIL mis_pulse: done %b mis %b exp 0 0", done_o, misaligned_o);
      end
      do_access(0, 1, 32'h4002, '0, cyc);
      checks++;
      if (cyc !== 2 || misaligned_o !== 1'b1 || req_seen !== 0) begin
         fails++; $display("FAIL mis_cap2: cyc %0d mis %b reqs %0d exp 2 1 0", cyc, misaligned_o, req_seen);
      end
      @(negedge clk);
      do_access(0, 1, 32'h4008, '0, cyc);
`ifdef CHERI_CAP_ALIGN_CHECK_EN
      checks++;
      if (cyc !== 2 || misaligned_o !== 1'b1 || req_seen !== 0) begin
         fails++; $display("FAIL mis_cap8: cyc %0d mis %b reqs %0d exp 2 1 0", cyc, misaligned_o, req_seen);
      end
`else
      exp = {29'hC, 32'hB, 32'hA};
      checks++;
      if (cyc !== 7 || misaligned_o !== 1'b0 || log_addr[2] !== 32'h4010) begin
         fails++; $display("FAIL cap8_access: cyc %0d mis %b addr2 %h exp 7 0 4010",
            cyc, misaligned_o, log_addr[2]);
      end
      checks++;
      if (rdata_o !== exp) begin fails++; $display("FAIL cap8_data: got %h exp %h", rdata_o, exp); end
`endif
   endtask

   task automatic test_back_to_back();
      int cyc;
      set_bus(-1, 0, -1, -1, 0, 32'h11112222, 0, 0);
      do_access(0, 0, 32'h1100, '0, cyc);
      checks++;
      if (cyc !== 3 || busy_o !== 1'b0) begin
         fails++; $display("FAIL b2b_first: cyc %0d busy %b exp 3 0", cyc, busy_o);
      end
      do_access(0, 0, 32'h1200, '0, cyc);
      checks++;
      if (cyc !== 3 || log_addr[0] !== 32'h1200) begin
         fails++; $display("FAIL b2b_second: cyc %0d addr %h exp 3 1200", cyc, log_addr[0]);
      end
      checks++;
      if (rdata_o !== CW'(32'h11112222)) begin fails++; $display("FAIL b2b_data: got %h exp 11112222", rdata_o); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit found;
      bit bad;
      found = 0; bad = 0;
      set_bus(-1, 0, -1, 1, 4, 32'h1, 32'h2, 32'h3);
      tr_id++;
      req_i = 1; we_i = 0; cap_i = 1; addr_i = 32'h5000;
      @(posedge clk); @(negedge clk);
      req_i = 0; cap_i = 0; addr_i = 0;
      for (int n = 0; n < 20; n++) begin
         if (g == 2 && busy_o === 1'b1 && data_req_o === 1'b0) begin found = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (found !== 1'b1) begin fails++; $display("FAIL rstmid_wait: beat1 WAIT got %b exp 1", found); end
      rst_i = 1;
      #1;
      checks++;
      if ({busy_o, done_o, data_req_o, err_o, misaligned_o} !== 5'b0 || rdata_o !== '0 || data_addr_o !== 32'h0) begin
         fails++; $display("FAIL rstmid_out: ctrl %b rdata %h addr %h exp 0 0 0",
            {busy_o, done_o, data_req_o, err_o, misaligned_o}, rdata_o, data_addr_o);
      end
      @(negedge clk);
      rst_i = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done_o !== 1'b0 || busy_o !== 1'b0) bad = 1;
      end
      checks++;
      if (bad !== 1'b0 || rv_cnt !== 2) begin
         fails++; $display("FAIL rstmid_late: disturbed %b responses %0d exp 0 2", bad, rv_cnt);
      end
      set_bus(-1, 0, -1, -1, 0, 32'hCAFE0001, 0, 0);
      do_access(0, 0, 32'h1000, '0, cyc);
      checks++;
      if (cyc !== 3 || rdata_o !== CW'(32'hCAFE0001) || err_o !== 1'b0) begin
         fails++; $display("FAIL rstmid_next: cyc %0d rdata %h err %b exp 3 CAFE0001 0", cyc, rdata_o, err_o);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_word_store();
      test_cap_store();
      test_cap_load_stall();
      test_cap_load_err();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
